// File: rtl/ara_pkg.sv
// Shared types and constants for the global load/store AXI path.
// Imported by the burst sequencer and its burst-length calculator.
package ara_pkg;

  localparam int unsigned PageBytes = 4096;

  typedef logic [7:0] axi_len_t;

  typedef enum logic [1:0] {
    EW8  = 2'd0,
    EW16 = 2'd1,
    EW32 = 2'd2,
    EW64 = 2'd3
  } vew_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN_ZERO
  } gbs_state_e;

endpackage

// File: rtl/global_burst_calc.sv
// Combinational length of the next INCR burst starting at cur_i.
// Limited by MaxAxiBurst, the last beat endb_i and the 4 KiB page.
module global_burst_calc
  import ara_pkg::*;
#(
  parameter int unsigned AxiAddrWidth = 64,
  parameter int unsigned AxiDataWidth = 128,
  parameter int unsigned MaxAxiBurst  = 16
) (
  input  logic [AxiAddrWidth-1:0] cur_i,
  input  logic [AxiAddrWidth-1:0] endb_i,
  output logic [AxiAddrWidth-1:0] beats_o,
  output logic                    last_o
);

  localparam int unsigned Size =
    $clog2(AxiDataWidth / 8);

  logic [AxiAddrWidth-1:0] w_end;
  logic [AxiAddrWidth-1:0] w_page;
  logic [AxiAddrWidth-1:0] w_max;
  logic [12:0]             w_room;

  assign w_end  = ((endb_i - cur_i) >> Size)
                + AxiAddrWidth'(1);
  assign w_room = 13'(PageBytes)
                - {1'b0, cur_i[11:0]};
  assign w_page = AxiAddrWidth'(w_room >> Size);
  assign w_max  = AxiAddrWidth'(MaxAxiBurst);

  always_comb begin
    beats_o = w_max;
    if (w_end < beats_o) beats_o = w_end;
    if (w_page < beats_o) beats_o = w_page;
  end

  assign last_o = (beats_o == w_end);

endmodule

// File: rtl/global_burst_sequencer.sv
// Splits one vector memory request into bus-aligned AXI INCR bursts,
// throttled by a count of bursts issued but not yet completed.
module global_burst_sequencer
  import ara_pkg::*;
#(
  parameter int unsigned AxiAddrWidth   = 64,
  parameter int unsigned AxiDataWidth   = 128,
  parameter int unsigned VlWidth        = 16,
  parameter int unsigned MaxAxiBurst    = 16,
  parameter int unsigned MaxOutstanding = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [AxiAddrWidth-1:0] req_addr_i,
  input  logic [VlWidth-1:0]      req_vl_i,
  input  logic [1:0]              req_vsew_i,
  output logic                    ax_valid_o,
  input  logic                    ax_ready_i,
  output logic [AxiAddrWidth-1:0] ax_addr_o,
  output logic [7:0]              ax_len_o,
  output logic                    ax_last_o,
  input  logic                    burst_done_i,
  output logic                    req_done_o,
  output logic [$clog2(MaxOutstanding+1)-1:0]
                                  outstanding_o
);

  localparam int unsigned AW   = AxiAddrWidth;
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
  localparam int unsigned BeatBytes = AxiDataWidth / 8;
  localparam int unsigned Size = $clog2(BeatBytes);
  localparam logic [AW-1:0] AlignMask = ~AW'(BeatBytes - 1);

  gbs_state_e r_state, w_state_nxt;

  logic [AW-1:0]   r_cur, r_endb, r_ax_addr;
  axi_len_t        r_ax_len;
  logic            r_ax_last, r_ax_valid, r_more;
  logic [CntW-1:0] r_cnt, w_cnt_nxt;

  logic [AW-1:0] w_bytes, w_cur0, w_endb0;
  logic [AW-1:0] w_calc_cur, w_calc_endb, w_beats;
  logic          w_last, w_idle, w_start, w_hs;
  logic          w_done_eff, w_room, w_load, w_req_done;

  assign w_idle  = (r_state == S_IDLE);
  assign w_start = w_idle & req_valid_i & (|req_vl_i);
  assign w_bytes = AW'(req_vl_i) << req_vsew_i;
  assign w_cur0  = req_addr_i & AlignMask;
  assign w_endb0 = (req_addr_i + w_bytes - AW'(1))
                 & AlignMask;

  // Compute the first burst straight from the request so the
  // first ax_valid_o appears the cycle after acceptance.
  assign w_calc_cur  = w_idle ? w_cur0 : r_cur;
  assign w_calc_endb = w_idle ? w_endb0 : r_endb;

  global_burst_calc #(
    .AxiAddrWidth (AxiAddrWidth),
    .AxiDataWidth (AxiDataWidth),
    .MaxAxiBurst  (MaxAxiBurst)
  ) i_calc (
    .cur_i   (w_calc_cur),
    .endb_i  (w_calc_endb),
    .beats_o (w_beats),
    .last_o  (w_last)
  );

  assign w_hs       = r_ax_valid & ax_ready_i;
  assign w_done_eff = burst_done_i & (r_cnt != '0);

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_hs & ~w_done_eff)
      w_cnt_nxt = r_cnt + CntW'(1);
    else if (~w_hs & w_done_eff)
      w_cnt_nxt = r_cnt - CntW'(1);
  end

  assign w_room = w_cnt_nxt < CntW'(MaxOutstanding);
  assign w_load = w_room & (w_start
                | ((r_state == S_ISSUE) & r_more
                   & (~r_ax_valid | w_hs)));

  always_comb begin
    w_state_nxt = r_state;
    w_req_done  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (req_valid_i)
          w_state_nxt = (|req_vl_i) ? S_ISSUE
                                    : S_DRAIN_ZERO;
      end
      S_ISSUE: begin
        if (w_hs & r_ax_last) begin
          w_req_done  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_DRAIN_ZERO: begin
        w_req_done  = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // r_cur always points at the next burst still to be loaded.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cur      <= '0;
      r_endb     <= '0;
      r_more     <= 1'b0;
      r_ax_addr  <= '0;
      r_ax_len   <= '0;
      r_ax_last  <= 1'b0;
      r_ax_valid <= 1'b0;
    end else if (w_load) begin
      r_ax_addr  <= w_calc_cur;
      r_ax_len   <= axi_len_t'(w_beats - AW'(1));
      r_ax_last  <= w_last;
      r_ax_valid <= 1'b1;
      r_cur      <= w_calc_cur + (w_beats << Size);
      r_endb     <= w_calc_endb;
      r_more     <= ~w_last;
    end else begin
      if (w_hs) r_ax_valid <= 1'b0;
      if (w_start) begin
        r_cur  <= w_cur0;
        r_endb <= w_endb0;
        r_more <= 1'b1;
      end
    end
  end

  assign req_ready_o   = w_idle;
  assign ax_valid_o    = r_ax_valid;
  assign ax_addr_o     = r_ax_addr;
  assign ax_len_o      = r_ax_len;
  assign ax_last_o     = r_ax_last;
  assign req_done_o    = w_req_done;
  assign outstanding_o = r_cnt;

  a_done_underflow: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    !(burst_done_i && (r_cnt == '0))
  );

endmodule

// File: tb/tb_global_burst_sequencer.sv
// Randomized bench for global_burst_sequencer against a
// burst-list reference model of the request splitting rules.
module tb_global_burst_sequencer;

  localparam int MAXB = 16;
  localparam int MAXO = 2;
  localparam int BB   = 16;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [63:0] req_addr_i = '0;
  logic [15:0] req_vl_i = '0;
  logic [1:0]  req_vsew_i = '0;
  logic        ax_valid_o;
  logic        ax_ready_i = 1'b0;
  logic [63:0] ax_addr_o;
  logic [7:0]  ax_len_o;
  logic        ax_last_o;
  logic        burst_done_i = 1'b0;
  logic        req_done_o;
  logic [1:0]  outstanding_o;

  always #5 clk = ~clk;

  global_burst_sequencer #(
    .AxiAddrWidth   (64),
    .AxiDataWidth   (128),
    .VlWidth        (16),
    .MaxAxiBurst    (MAXB),
    .MaxOutstanding (MAXO)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .req_addr_i    (req_addr_i),
    .req_vl_i      (req_vl_i),
    .req_vsew_i    (req_vsew_i),
    .ax_valid_o    (ax_valid_o),
    .ax_ready_i    (ax_ready_i),
    .ax_addr_o     (ax_addr_o),
    .ax_len_o      (ax_len_o),
    .ax_last_o     (ax_last_o),
    .burst_done_i  (burst_done_i),
    .req_done_o    (req_done_o),
    .outstanding_o (outstanding_o)
  );

  int n_chk = 0;
  int n_err = 0;

  logic [63:0] q_addr[$];
  int          q_len[$];
  bit          q_last[$];
  int          m_cnt = 0;
  bit          fin;
  bit          pv = 0;
  logic [63:0] paddr;
  logic [7:0]  plen;
  logic        plast;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic build(input logic [63:0] a,
                       input int vl, input int sew);
    logic [63:0] cur, e;
    int rem, room, n;
    q_addr.delete(); q_len.delete(); q_last.delete();
    if (vl == 0) return;
    cur = a & ~64'(BB - 1);
    e = (a + (64'(vl) << sew) - 64'd1) & ~64'(BB - 1);
    forever begin
      rem  = int'((e - cur) / BB) + 1;
      room = (4096 - int'(cur % 4096)) / BB;
      n = MAXB;
      if (rem < n) n = rem;
      if (room < n) n = room;
      q_addr.push_back(cur);
      q_len.push_back(n - 1);
      q_last.push_back(n == rem);
      if (n == rem) break;
      cur += 64'(n * BB);
    end
  endtask

  task automatic step(input int rp, input int dp,
                      input bit cd);
    bit hs, lt;
    logic [63:0] ea;
    int el;
    burst_done_i = (m_cnt > 0) &&
                   ($urandom_range(99) < dp);
    ax_ready_i = ($urandom_range(99) < rp);
    #1;
    hs = ax_valid_o && ax_ready_i;
    lt = 0;
    if (pv) begin
      chk("stable_addr", ax_addr_o, paddr);
      chk("stable_len", ax_len_o, plen);
      chk("stable_last", ax_last_o, plast);
    end
    if (ax_valid_o) chk("throttle", 64'(m_cnt < MAXO), 1);
    if (hs) begin
      if (q_addr.size() == 0) begin
        chk("unexpected_burst", ax_valid_o, 0);
      end else begin
        ea = q_addr.pop_front();
        el = q_len.pop_front();
        lt = q_last.pop_front();
        chk("ax_addr", ax_addr_o, ea);
        chk("ax_len", ax_len_o, 64'(el));
        chk("ax_last", ax_last_o, lt);
      end
    end
    if (cd) chk("req_done", req_done_o, hs && lt);
    pv = ax_valid_o && !ax_ready_i;
    paddr = ax_addr_o;
    plen = ax_len_o;
    plast = ax_last_o;
    if (hs && lt) fin = 1;
    m_cnt = m_cnt + int'(hs) - int'(burst_done_i);
    @(posedge clk);
    @(negedge clk);
    chk("outstanding", outstanding_o, 64'(m_cnt));
  endtask

  task automatic run_req(input logic [63:0] a,
                         input int vl, input int sew,
                         input int rp, input int dp);
    int n;
    build(a, vl, sew);
    fin = 0;
    chk("ready_idle", req_ready_o, 1);
    req_valid_i = 1;
    req_addr_i = a;
    req_vl_i = 16'(vl);
    req_vsew_i = 2'(sew);
    step(rp, dp, 1);
    req_valid_i = 0;
    if (vl == 0) begin
      chk("zero_done", req_done_o, 1);
      chk("zero_novalid", ax_valid_o, 0);
      step(rp, dp, 0);
      chk("zero_done_end", req_done_o, 0);
      chk("zero_ready", req_ready_o, 1);
      chk("zero_novalid2", ax_valid_o, 0);
    end else begin
      n = 0;
      while (!fin && n < 3000) begin
        chk("ready_busy", req_ready_o, 0);
        chk("valid", ax_valid_o,
            64'(q_addr.size() > 0 && m_cnt < MAXO));
        step(rp, dp, 1);
        n++;
      end
      chk("timeout", fin, 1);
      chk("ready_after", req_ready_o, 1);
      chk("valid_after", ax_valid_o, 0);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (m_cnt > 0 && n < 100) begin
      step(0, 100, 0);
      n++;
    end
    burst_done_i = 0;
    chk("drained", outstanding_o, 0);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_ready"}, req_ready_o, 1);
    chk({tag, "_valid"}, ax_valid_o, 0);
    chk({tag, "_addr"}, ax_addr_o, 0);
    chk({tag, "_len"}, ax_len_o, 0);
    chk({tag, "_last"}, ax_last_o, 0);
    chk({tag, "_done"}, req_done_o, 0);
    chk({tag, "_outst"}, outstanding_o, 0);
  endtask

  initial begin
    logic [63:0] a;
    repeat (2) @(negedge clk);
    chk_reset_outs("rst");
    rst_ni = 1;
    @(negedge clk);

    run_req(64'h1000, 64, 2, 100, 50);
    run_req(64'h1004, 64, 2, 100, 50);
    run_req(64'h1FC0, 32, 2, 100, 50);
    run_req(64'h2008, 200, 3, 15, 30);
    run_req(64'h3008, 0, 1, 100, 50);
    drain();

    // throttle: two bursts in flight, then wait for completions
    pv = 0;
    ax_ready_i = 1;
    req_valid_i = 1;
    req_addr_i = 64'h0;
    req_vl_i = 16'd256;
    req_vsew_i = 2'd2;
    @(negedge clk);
    req_valid_i = 0;
    chk("thr_v0", ax_valid_o, 1);
    chk("thr_a0", ax_addr_o, 64'h0);
    @(negedge clk);
    chk("thr_v1", ax_valid_o, 1);
    chk("thr_a1", ax_addr_o, 64'h100);
    chk("thr_o1", outstanding_o, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("thr_hold_v", ax_valid_o, 0);
      chk("thr_hold_o", outstanding_o, 2);
    end
    burst_done_i = 1;
    @(negedge clk);
    burst_done_i = 0;
    chk("thr_v2", ax_valid_o, 1);
    chk("thr_a2", ax_addr_o, 64'h200);
    chk("thr_o2", outstanding_o, 1);
    @(negedge clk);
    chk("thr_v2_off", ax_valid_o, 0);
    chk("thr_o2b", outstanding_o, 2);
    burst_done_i = 1;
    @(negedge clk);
    burst_done_i = 0;
    #1;
    chk("thr_a3", ax_addr_o, 64'h300);
    chk("thr_l3", ax_last_o, 1);
    chk("thr_done", req_done_o, 1);
    @(negedge clk);
    chk("thr_end_v", ax_valid_o, 0);
    chk("thr_end_r", req_ready_o, 1);
    chk("thr_end_o", outstanding_o, 2);
    ax_ready_i = 0;
    m_cnt = 2;
    drain();

    // asynchronous reset during the second burst
    req_valid_i = 1;
    req_addr_i = 64'h4000;
    req_vl_i = 16'd256;
    req_vsew_i = 2'd2;
    @(negedge clk);
    req_valid_i = 0;
    ax_ready_i = 1;
    @(negedge clk);
    ax_ready_i = 0;
    chk("mid_v", ax_valid_o, 1);
    chk("mid_a", ax_addr_o, 64'h4100);
    rst_ni = 0;
    #1;
    chk_reset_outs("arst");
    @(negedge clk);
    rst_ni = 1;
    m_cnt = 0;
    pv = 0;
    @(negedge clk);
    run_req(64'h5010, 40, 2, 70, 50);

    for (int i = 0; i < 40; i++) begin
      a = {$urandom, $urandom} & 64'h0000_FFFF_FFFF_FFFF;
      if ($urandom_range(3) == 0)
        a = (a & ~64'hFFF) | 64'(12'hF00 + $urandom_range(255));
      run_req(a, int'($urandom_range(300)),
              int'($urandom_range(3)),
              int'($urandom_range(100, 30)),
              int'($urandom_range(90, 20)));
    end
    drain();

    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

endmodule
